counter_down_100: RTL and testbench

- Loadable down-counter/timer; the count-down counterpart of the team's free-running 0..99 up-counter (counter_100).
- Loads a start value (0..99), decrements once per clock to 0, and flags terminal count.
- Optional auto-reload turns it into a periodic tick generator.
- Sits beside counter_100 in the timing/counter library and drives downstream timeout and tick logic.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_down_100.sv | 123 ++++++++++++
 tb/tb_counter_down_100.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter library (counter_100, counter_down_100).
// Keeps the FSM state encoding and the default count range in one place so
// the up- and down-counters stay consistent.
package counter_pkg;

   localparam int CNT_WIDTH_DEF = 7;
   localparam int CNT_MAX_DEF   = 99;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_e;

endpackage : counter_pkg

// File: rtl/counter_down_100.sv
// Loadable down-counter / timer. A start loads a clamped value, the count then
// decrements once per clock to zero and flags terminal count on o_done. With
// auto-reload enabled the terminal cycle reloads the last start value, which
// turns the block into a periodic tick generator with a period of L+1 cycles.
module counter_down_100
   import counter_pkg::*;
#(
   parameter int CNT_WIDTH = CNT_WIDTH_DEF,
   parameter int CNT_MAX   = CNT_MAX_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic                 i_pause,
   input  logic                 i_reload_en,
   input  logic [CNT_WIDTH-1:0] i_load_val,
   output logic [CNT_WIDTH-1:0] o_cnt,
   output logic                 o_busy,
   output logic                 o_paused,
   output logic                 o_done
);

   localparam logic [CNT_WIDTH-1:0] MAX_VAL = CNT_WIDTH'(CNT_MAX);
   localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] reload_q, reload_d;
   logic                 busy_q, busy_d;
   logic                 paused_q, paused_d;
   logic                 done_q, done_d;
   logic [CNT_WIDTH-1:0] load_clamped;

   // Out-of-range start values saturate at the top of the legal range, so the
   // count can never exceed CNT_MAX no matter what the load bus carries.
   always_comb begin
      load_clamped = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;
   end

   // Next-state decision. Priority on a single edge is stop, then start, then
   // the terminal-count action, then pause, then a plain decrement. Pause is
   // deliberately not checked on the terminal cycle so a period cannot be
   // stretched into a second o_done. The status flags are computed from the
   // next state so that they can be registered alongside it.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;

      if (i_stop) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (i_start) begin
         state_d  = ST_RUN;
         cnt_d    = load_clamped;
         reload_d = load_clamped;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
            end
            ST_RUN: begin
               if (cnt_q == '0) begin
                  if (i_reload_en) begin
                     cnt_d = reload_q;
                  end else begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
               end else if (i_pause) begin
                  state_d = ST_PAUSE;
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            ST_PAUSE: begin
               if (!i_pause) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      busy_d   = (state_d != ST_IDLE);
      paused_d = (state_d == ST_PAUSE);
      done_d   = (state_d == ST_RUN) && (cnt_d == '0);
   end

   // State, count, reload value and status flags all live in flops; the
   // asynchronous reset clears everything so a mid-count reset never reports
   // a terminal count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         busy_q   <= 1'b0;
         paused_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         busy_q   <= busy_d;
         paused_q <= paused_d;
         done_q   <= done_d;
      end
   end

   // Outputs come straight from the flops.
   always_comb begin
      o_cnt    = cnt_q;
      o_busy   = busy_q;
      o_paused = paused_q;
      o_done   = done_q;
   end

endmodule : counter_down_100

// File: tb/tb_counter_down_100.sv
// Self-checking bench for counter_down_100: a table of per-cycle vectors plus
// hand-written sequences for long periods, clamping and asynchronous reset.
// Each driven cycle pushes its expected outputs onto a scoreboard queue that is
// popped when the outputs are sampled after the clock edge.
module tb_counter_down_100;

   typedef struct {
      logic       start;
      logic       stop;
      logic       pause;
      logic       reload;
      logic [6:0] load;
      logic [6:0] cnt;
      logic       busy;
      logic       paused;
      logic       done;
      string      name;
   } vec_t;

   typedef struct {
      logic [6:0] cnt;
      logic       busy;
      logic       paused;
      logic       done;
      string      name;
   } exp_t;

   logic       clk;
   logic       reset_n;
   logic       i_start;
   logic       i_stop;
   logic       i_pause;
   logic       i_reload_en;
   logic [6:0] i_load_val;
   logic [6:0] o_cnt;
   logic       o_busy;
   logic       o_paused;
   logic       o_done;

   int   checks;
   int   failures;
   exp_t expQ[$];
   vec_t vecs[$];

   counter_down_100 dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_start    (i_start),
      .i_stop     (i_stop),
      .i_pause    (i_pause),
      .i_reload_en(i_reload_en),
      .i_load_val (i_load_val),
      .o_cnt      (o_cnt),
      .o_busy     (o_busy),
      .o_paused   (o_paused),
      .o_done     (o_done)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a run that never reaches its summary.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic start, input logic stop, input logic pause,
                               input logic reload, input logic [6:0] load,
                               input logic [6:0] cnt, input logic busy,
                               input logic paused, input logic done, input string name);
      vec_t v;
      v.start  = start;
      v.stop   = stop;
      v.pause  = pause;
      v.reload = reload;
      v.load   = load;
      v.cnt    = cnt;
      v.busy   = busy;
      v.paused = paused;
      v.done   = done;
      v.name   = name;
      return v;
   endfunction

   task automatic pushExp(input logic [6:0] cnt, input logic busy, input logic paused,
                          input logic done, input string name);
      exp_t e;
      e.cnt    = cnt;
      e.busy   = busy;
      e.paused = paused;
      e.done   = done;
      e.name   = name;
      expQ.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      checks++;
      if (expQ.size() == 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_empty: outputs sampled with no expectation queued");
         return;
      end
      e = expQ.pop_front();
      if (o_cnt !== e.cnt || o_busy !== e.busy || o_paused !== e.paused || o_done !== e.done) begin
         failures++;
         $display("[TB] FAIL %s: got cnt=%0d busy=%b paused=%b done=%b, expected cnt=%0d busy=%b paused=%b done=%b",
                  e.name, o_cnt, o_busy, o_paused, o_done, e.cnt, e.busy, e.paused, e.done);
      end
   endtask

   // Drive one cycle of inputs on the falling edge, queue its expectation and
   // compare just after the following rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      i_start     = v.start;
      i_stop      = v.stop;
      i_pause     = v.pause;
      i_reload_en = v.reload;
      i_load_val  = v.load;
      pushExp(v.cnt, v.busy, v.paused, v.done, v.name);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic step(input logic start, input logic stop, input logic pause,
                       input logic reload, input logic [6:0] load,
                       input logic [6:0] cnt, input logic busy,
                       input logic paused, input logic done, input string name);
      applyStimulus(mk(start, stop, pause, reload, load, cnt, busy, paused, done, name));
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset_n     = 1'b0;
      i_start     = 1'b0;
      i_stop      = 1'b0;
      i_pause     = 1'b0;
      i_reload_en = 1'b0;
      i_load_val  = '0;

      #3;
      pushExp(7'd0, 1'b0, 1'b0, 1'b0, "reset_state");
      checkOutput();
      @(negedge clk);
      reset_n = 1'b1;

      // Load 5, no reload: 5..0, one done, then idle.
      vecs.push_back(mk(1, 0, 0, 0, 7'd5, 7'd5, 1, 0, 0, "l5_start"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd4, 1, 0, 0, "l5_c4"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd3, 1, 0, 0, "l5_c3"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd2, 1, 0, 0, "l5_c2"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd1, 1, 0, 0, "l5_c1"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd0, 1, 0, 1, "l5_done"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd0, 0, 0, 0, "l5_idle"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd0, 0, 0, 0, "l5_idle2"));
      // Load 10, pause at 3 for four cycles, resume without a decrement.
      vecs.push_back(mk(1, 0, 0, 0, 7'd10, 7'd10, 1, 0, 0, "p_start"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd9, 1, 0, 0, "p_c9"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd8, 1, 0, 0, "p_c8"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd7, 1, 0, 0, "p_c7"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd6, 1, 0, 0, "p_c6"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd5, 1, 0, 0, "p_c5"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd4, 1, 0, 0, "p_c4"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd3, 1, 0, 0, "p_c3"));
      vecs.push_back(mk(0, 0, 1, 0, 7'd0, 7'd3, 1, 1, 0, "p_hold1"));
      vecs.push_back(mk(0, 0, 1, 0, 7'd0, 7'd3, 1, 1, 0, "p_hold2"));
      vecs.push_back(mk(0, 0, 1, 0, 7'd0, 7'd3, 1, 1, 0, "p_hold3"));
      vecs.push_back(mk(0, 0, 1, 0, 7'd0, 7'd3, 1, 1, 0, "p_hold4"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd3, 1, 0, 0, "p_resume"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd2, 1, 0, 0, "p_c2"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd1, 1, 0, 0, "p_c1"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd0, 1, 0, 1, "p_done"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd0, 0, 0, 0, "p_idle"));
      // Stop and start together during RUN: stop wins, no done.
      vecs.push_back(mk(1, 0, 0, 0, 7'd8, 7'd8, 1, 0, 0, "ss_start"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd7, 1, 0, 0, "ss_c7"));
      vecs.push_back(mk(1, 1, 0, 0, 7'd50, 7'd0, 0, 0, 0, "ss_both"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd0, 0, 0, 0, "ss_idle"));
      vecs.push_back(mk(1, 0, 0, 0, 7'd3, 7'd3, 1, 0, 0, "ss_restart"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd2, 1, 0, 0, "ss_c2"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd1, 1, 0, 0, "ss_c1"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd0, 1, 0, 1, "ss_done"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd0, 0, 0, 0, "ss_idle2"));
      // Pause ignored on the terminal cycle; reload wins.
      vecs.push_back(mk(1, 0, 0, 1, 7'd2, 7'd2, 1, 0, 0, "tp_start"));
      vecs.push_back(mk(0, 0, 0, 1, 7'd0, 7'd1, 1, 0, 0, "tp_c1"));
      vecs.push_back(mk(0, 0, 0, 1, 7'd0, 7'd0, 1, 0, 1, "tp_done"));
      vecs.push_back(mk(0, 0, 1, 1, 7'd0, 7'd2, 1, 0, 0, "tp_reload"));
      vecs.push_back(mk(0, 0, 1, 1, 7'd0, 7'd2, 1, 1, 0, "tp_pause"));
      vecs.push_back(mk(0, 1, 0, 1, 7'd0, 7'd0, 0, 0, 0, "tp_stop"));
      // Zero load with and without reload.
      vecs.push_back(mk(1, 0, 0, 1, 7'd0, 7'd0, 1, 0, 1, "z_rl_start"));
      vecs.push_back(mk(0, 0, 0, 1, 7'd0, 7'd0, 1, 0, 1, "z_rl_hold1"));
      vecs.push_back(mk(0, 0, 0, 1, 7'd0, 7'd0, 1, 0, 1, "z_rl_hold2"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd0, 0, 0, 0, "z_rl_end"));
      vecs.push_back(mk(1, 0, 0, 0, 7'd0, 7'd0, 1, 0, 1, "z_start"));
      vecs.push_back(mk(0, 0, 0, 0, 7'd0, 7'd0, 0, 0, 0, "z_idle"));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
      end

      // Load 120 clamps to 99; done on the hundredth cycle.
      for (int k = 0; k < 100; k++) begin
         step(logic'(k == 0), 0, 0, 0, 7'd120, 7'(99 - k), 1, 0, logic'(k == 99), "clamp");
      end
      step(0, 0, 0, 0, 7'd0, 7'd0, 0, 0, 0, "clamp_idle");

      // Load 99 with reload: 100-cycle period for three periods.
      for (int k = 0; k < 300; k++) begin
         step(logic'(k == 0), 0, 0, 1, 7'd99, 7'(99 - (k % 100)), 1, 0,
              logic'((k % 100) == 99), "reload99");
      end
      step(0, 1, 0, 1, 7'd0, 7'd0, 0, 0, 0, "reload99_stop");

      // Asynchronous reset at count 7 clears outputs before any clock edge.
      step(1, 0, 0, 0, 7'd10, 7'd10, 1, 0, 0, "ar_start");
      step(0, 0, 0, 0, 7'd0, 7'd9, 1, 0, 0, "ar_c9");
      step(0, 0, 0, 0, 7'd0, 7'd8, 1, 0, 0, "ar_c8");
      step(0, 0, 0, 0, 7'd0, 7'd7, 1, 0, 0, "ar_c7");
      #2;
      reset_n = 1'b0;
      #1;
      pushExp(7'd0, 1'b0, 1'b0, 1'b0, "ar_async");
      checkOutput();
      @(posedge clk);
      #1;
      pushExp(7'd0, 1'b0, 1'b0, 1'b0, "ar_held");
      checkOutput();
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 0, 0, 0, 7'd0, 7'd0, 0, 0, 0, "ar_idle1");
      step(0, 0, 0, 1, 7'd0, 7'd0, 0, 0, 0, "ar_idle2");
      step(1, 0, 0, 0, 7'd4, 7'd4, 1, 0, 0, "ar_restart");
      step(0, 0, 0, 0, 7'd0, 7'd3, 1, 0, 0, "ar_c3");

      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_leftover: %0d expectations never compared, expected 0", expQ.size());
      end
      checks++;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_counter_down_100
